// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: hazard controller for the 5-stage core.
//  - ID-stage operand forwarding for NUM_SRC operands, priority EX > MEM > WB.
//  - Load-use stall of LOAD_LAT cycles.
//  - Stall while a multi-cycle mul/div op sits in EX.
//  - Optional performance counters, enabled by defining HAZARD_PERF_CNT_EN.

`ifndef WD_SEL_FROM_DRAM
`define WD_SEL_FROM_DRAM 2'd1
`endif

module hazard_ctrl_mc #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef HAZARD_PERF_CNT_EN
  input  logic                    perf_clr,
  output logic [CNT_W-1:0]        perf_stall_cnt,
  output logic [CNT_W-1:0]        perf_flush_cnt,
`endif
  input  logic [1:0]              wd_sel_EX,
  input  logic [NUM_SRC-1:0]      rs_used_ID,
  input  logic [5*NUM_SRC-1:0]    rR_ID,
  input  logic [4:0]              wR_EX,
  input  logic [4:0]              wR_MEM,
  input  logic [4:0]              wR_WB,
  input  logic                    rf_we_EX,
  input  logic                    rf_we_MEM,
  input  logic                    rf_we_WB,
  input  logic [XLEN-1:0]         rf_wd_EX,
  input  logic [XLEN-1:0]         rf_wd_MEM,
  input  logic [XLEN-1:0]         rf_wd_WB,
  input  logic                    take_branch_EX,
  input  logic                    md_start_EX,
  input  logic                    md_done,
  output logic                    keep_pc,
  output logic                    stall_IF_ID,
  output logic                    stall_ID_EX,
  output logic                    flush_IF_ID,
  output logic                    flush_ID_EX,
  output logic                    flush_EX_MEM,
  output logic [NUM_SRC-1:0]      fwd_en_ID,
  output logic [XLEN*NUM_SRC-1:0] fwd_data_ID,
  output logic [1:0]              hz_state
);

  // Wide enough to hold LOAD_LAT-1, the number of wait cycles after the first stall.
  localparam int CNT_BITS = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_MD_WAIT   = 2'd2
  } hz_state_e;

  hz_state_e            state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  logic [NUM_SRC-1:0]   raw_ex;
  logic [NUM_SRC-1:0]   raw_mem;
  logic [NUM_SRC-1:0]   raw_wb;
  logic                 load_use;

  // ---------------------------------------------------------------------------
  // Forwarding: per-operand RAW detection against each later stage. x0 never
  // forwards. The youngest producer (EX) wins. Everything is forced to zero
  // while reset is held.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
    logic [4:0] rr;
    assign rr = rR_ID[5*gi +: 5];

    assign raw_ex[gi]  = rs_used_ID[gi] && rf_we_EX  && (wR_EX  == rr) && (wR_EX  != 5'd0);
    assign raw_mem[gi] = rs_used_ID[gi] && rf_we_MEM && (wR_MEM == rr) && (wR_MEM != 5'd0);
    assign raw_wb[gi]  = rs_used_ID[gi] && rf_we_WB  && (wR_WB  == rr) && (wR_WB  != 5'd0);

    assign fwd_en_ID[gi] = !rst && (raw_ex[gi] || raw_mem[gi] || raw_wb[gi]);

    assign fwd_data_ID[XLEN*gi +: XLEN] =
        rst         ? '0        :
        raw_ex[gi]  ? rf_wd_EX  :
        raw_mem[gi] ? rf_wd_MEM :
        raw_wb[gi]  ? rf_wd_WB  : '0;
  end

  // A load in EX cannot forward: its data only exists after MEM.
  assign load_use = (wd_sel_EX == `WD_SEL_FROM_DRAM) && (|raw_ex);

  // State register and load-wait counter; async reset aborts any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall/flush outputs; reset forces every control output low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    keep_pc      = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (take_branch_EX) begin
          // The branch squashes the ID instruction, so no hazard remains.
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
        end else if (load_use) begin
          // First bubble is issued here; further bubbles come from LOAD_WAIT.
          keep_pc     = 1'b1;
          stall_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_LOAD_WAIT;
            cnt_d   = CNT_BITS'(LOAD_LAT - 1);
          end
        end else if (md_start_EX && !md_done) begin
          keep_pc      = 1'b1;
          stall_IF_ID  = 1'b1;
          stall_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
          state_d      = ST_MD_WAIT;
        end
      end

      ST_LOAD_WAIT: begin
        // EX holds a bubble now, so branch and mul/div inputs are irrelevant.
        keep_pc     = 1'b1;
        stall_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q <= CNT_BITS'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      ST_MD_WAIT: begin
        if (!md_done) begin
          keep_pc      = 1'b1;
          stall_IF_ID  = 1'b1;
          stall_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (rst) begin
      keep_pc      = 1'b0;
      stall_IF_ID  = 1'b0;
      stall_ID_EX  = 1'b0;
      flush_IF_ID  = 1'b0;
      flush_ID_EX  = 1'b0;
      flush_EX_MEM = 1'b0;
    end
  end

  assign hz_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counter next values: clear has priority, otherwise count and wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (keep_pc)     stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_IF_ID) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Testbench for hazard_ctrl_mc: two instances (LOAD_LAT=3 and 4) share stimulus.
// A behavioural model (remaining-bubble count, mul/div busy flag) predicts
// every output each cycle; directed literal checks pin the model.
// Define HAZARD_PERF_CNT_EN to include the perf counter checks.

module tb_hazard_ctrl_mc;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 8;
  localparam logic [1:0] WD_LOAD = 2'd1;   // writeback select value for loads

  // Control output bit order: {keep_pc, stall_IF_ID, stall_ID_EX, flush_IF_ID, flush_ID_EX, flush_EX_MEM}
  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_LOAD   = 6'b110010;
  localparam logic [5:0] C_MD     = 6'b111001;
  localparam logic [5:0] C_BRANCH = 6'b000110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]              wd_sel_EX;
  logic [NUM_SRC-1:0]      rs_used_ID;
  logic [5*NUM_SRC-1:0]    rR_ID;
  logic [4:0]              wR_EX, wR_MEM, wR_WB;
  logic                    rf_we_EX, rf_we_MEM, rf_we_WB;
  logic [XLEN-1:0]         rf_wd_EX, rf_wd_MEM, rf_wd_WB;
  logic                    take_branch_EX, md_start_EX, md_done;
  logic                    perf_clr;

  logic [5:0]              ctrl_o [2];
  logic [NUM_SRC-1:0]      fen_o  [2];
  logic [XLEN*NUM_SRC-1:0] fdat_o [2];
  logic [1:0]              st_o   [2];
  logic [CNT_W-1:0]        pst_o  [2];
  logic [CNT_W-1:0]        pfl_o  [2];

  int lat_of [2] = '{3, 4};

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic kp, sif, sid, fif, fid, fem;
    logic [NUM_SRC-1:0]      fen;
    logic [XLEN*NUM_SRC-1:0] fdat;
    logic [1:0]              st;
    logic [CNT_W-1:0]        pst, pfl;

    hazard_ctrl_mc #(
      .XLEN(XLEN), .NUM_SRC(NUM_SRC), .LOAD_LAT(gi == 0 ? 3 : 4), .CNT_W(CNT_W)
    ) dut (
      .clk(clk), .rst(rst),
`ifdef HAZARD_PERF_CNT_EN
      .perf_clr(perf_clr), .perf_stall_cnt(pst), .perf_flush_cnt(pfl),
`endif
      .wd_sel_EX(wd_sel_EX), .rs_used_ID(rs_used_ID), .rR_ID(rR_ID),
      .wR_EX(wR_EX), .wR_MEM(wR_MEM), .wR_WB(wR_WB),
      .rf_we_EX(rf_we_EX), .rf_we_MEM(rf_we_MEM), .rf_we_WB(rf_we_WB),
      .rf_wd_EX(rf_wd_EX), .rf_wd_MEM(rf_wd_MEM), .rf_wd_WB(rf_wd_WB),
      .take_branch_EX(take_branch_EX), .md_start_EX(md_start_EX), .md_done(md_done),
      .keep_pc(kp), .stall_IF_ID(sif), .stall_ID_EX(sid),
      .flush_IF_ID(fif), .flush_ID_EX(fid), .flush_EX_MEM(fem),
      .fwd_en_ID(fen), .fwd_data_ID(fdat), .hz_state(st)
    );

`ifndef HAZARD_PERF_CNT_EN
    assign pst = '0;
    assign pfl = '0;
`endif
    assign ctrl_o[gi] = {kp, sif, sid, fif, fid, fem};
    assign fen_o[gi]  = fen;
    assign fdat_o[gi] = fdat;
    assign st_o[gi]   = st;
    assign pst_o[gi]  = pst;
    assign pfl_o[gi]  = pfl;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         ld_left [2];   // load bubbles still owed after the current cycle
  bit         md_busy [2];   // a mul/div op has already stalled at least one cycle
  logic [CNT_W-1:0] m_stall [2];
  logic [CNT_W-1:0] m_flush [2];

  function automatic bit m_match(input logic [4:0] wr, input logic we, input int i);
    return rs_used_ID[i] && we && (wr != 5'd0) && (wr == rR_ID[5*i +: 5]);
  endfunction

  function automatic bit m_load_use();
    bit r = 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (m_match(wR_EX, rf_we_EX, i)) r = 1;
    return (wd_sel_EX == WD_LOAD) && r;
  endfunction

  function automatic logic [5:0] exp_ctrl(input int k);
    if (rst)                        return C_NONE;
    if (ld_left[k] > 0)             return C_LOAD;
    if (md_busy[k])                 return md_done ? C_NONE : C_MD;
    if (take_branch_EX)             return C_BRANCH;
    if (m_load_use())               return C_LOAD;
    if (md_start_EX && !md_done)    return C_MD;
    return C_NONE;
  endfunction

  function automatic logic [1:0] exp_state(input int k);
    if (rst)            return 2'd0;
    if (ld_left[k] > 0) return 2'd1;
    if (md_busy[k])     return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [NUM_SRC+XLEN*NUM_SRC-1:0] exp_fwd();
    logic [NUM_SRC-1:0]      en  = '0;
    logic [XLEN*NUM_SRC-1:0] dat = '0;
    logic [4:0]      wr [3];
    logic            we [3];
    logic [XLEN-1:0] wd [3];
    wr[0] = wR_EX;    wr[1] = wR_MEM;    wr[2] = wR_WB;
    we[0] = rf_we_EX; we[1] = rf_we_MEM; we[2] = rf_we_WB;
    wd[0] = rf_wd_EX; wd[1] = rf_wd_MEM; wd[2] = rf_wd_WB;
    if (!rst)
      for (int i = 0; i < NUM_SRC; i++)
        for (int s = 0; s < 3; s++)
          if (!en[i] && m_match(wr[s], we[s], i)) begin
            en[i] = 1'b1;
            dat[XLEN*i +: XLEN] = wd[s];
          end
    return {en, dat};
  endfunction

  // Model state advance at each clock; async reset clears everything.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        ld_left[k] <= 0;
        md_busy[k] <= 1'b0;
        m_stall[k] <= '0;
        m_flush[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic logic [5:0] c = exp_ctrl(k);
        m_stall[k] <= perf_clr ? '0 : m_stall[k] + CNT_W'(c[5]);
        m_flush[k] <= perf_clr ? '0 : m_flush[k] + CNT_W'(c[2]);
        if (ld_left[k] > 0)
          ld_left[k] <= ld_left[k] - 1;
        else if (md_busy[k]) begin
          if (md_done) md_busy[k] <= 1'b0;
        end else if (!take_branch_EX && m_load_use())
          ld_left[k] <= lat_of[k] - 1;
        else if (!take_branch_EX && md_start_EX && !md_done)
          md_busy[k] <= 1'b1;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic logic [NUM_SRC+XLEN*NUM_SRC-1:0] f = exp_fwd();
      chk("ctrl", k, 64'(ctrl_o[k]), 64'(exp_ctrl(k)));
      chk("hz_state", k, 64'(st_o[k]), 64'(exp_state(k)));
      chk("fwd_en", k, 64'(fen_o[k]), 64'(f[NUM_SRC+XLEN*NUM_SRC-1 -: NUM_SRC]));
      chk("fwd_data", k, 64'(fdat_o[k]), 64'(f[XLEN*NUM_SRC-1:0]));
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall", k, 64'(pst_o[k]), 64'(m_stall[k]));
      chk("perf_flush", k, 64'(pfl_o[k]), 64'(m_flush[k]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    wd_sel_EX = 2'd0; rs_used_ID = '0; rR_ID = '0;
    wR_EX = 5'd0; wR_MEM = 5'd0; wR_WB = 5'd0;
    rf_we_EX = 1'b0; rf_we_MEM = 1'b0; rf_we_WB = 1'b0;
    rf_wd_EX = '0; rf_wd_MEM = '0; rf_wd_WB = '0;
    take_branch_EX = 1'b0; md_start_EX = 1'b0; md_done = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load_use();
    idle_in();
    wd_sel_EX  = WD_LOAD;
    wR_EX      = 5'd7;
    rf_we_EX   = 1'b1;
    rf_wd_EX   = 32'hDEAD_0007;
    rR_ID      = {5'd7, 5'd0};
    rs_used_ID = 2'b10;
  endtask

  initial begin
    rst = 1'b1;
    perf_clr = 1'b0;
    idle_in();
    #2;
    chk("rst_ctrl", 0, 64'(ctrl_o[0]), 64'(C_NONE));
    chk("rst_state", 1, 64'(st_o[1]), 64'd0);
    step(); step();
    rst = 1'b0;

    // 1: forwarding priority and x0 suppression
    wR_EX = 5'd5; wR_MEM = 5'd5; wR_WB = 5'd5;
    rf_we_EX = 1'b1; rf_we_MEM = 1'b1; rf_we_WB = 1'b1;
    rf_wd_EX = 32'h11; rf_wd_MEM = 32'h22; rf_wd_WB = 32'h33;
    rR_ID = {5'd0, 5'd5}; rs_used_ID = 2'b01;
    #3;
    chk("t1_en", 0, 64'(fen_o[0]), 64'b01);
    chk("t1_data", 0, 64'(fdat_o[0]), 64'h11);
    step();
    wR_EX = 5'd3;
    #3;
    chk("t1_mem_prio", 0, 64'(fdat_o[0]), 64'h22);
    step();
    wR_EX = 5'd0; wR_MEM = 5'd0; wR_WB = 5'd0; rR_ID = {5'd0, 5'd0};
    #3;
    chk("t1_x0_en", 0, 64'(fen_o[0]), 64'b00);
    chk("t1_x0_data", 0, 64'(fdat_o[0]), 64'h0);
    step();

    // 2: load-use, bubbles 3 (dut0) / 4 (dut1)
    drive_load_use();
    #3;
    chk("t2_c1", 0, 64'(ctrl_o[0]), 64'(C_LOAD));
    chk("t2_s1", 0, 64'(st_o[0]), 64'd0);
    step();
    idle_in();
    #3;
    chk("t2_c2", 0, 64'(ctrl_o[0]), 64'(C_LOAD));
    chk("t2_s2", 0, 64'(st_o[0]), 64'd1);
    step();
    take_branch_EX = 1'b1;   // ignored while waiting on the load
    #3;
    chk("t2_c3", 0, 64'(ctrl_o[0]), 64'(C_LOAD));
    chk("t2_s3", 0, 64'(st_o[0]), 64'd1);
    step();
    take_branch_EX = 1'b0;
    #3;
    chk("t2_c4", 0, 64'(ctrl_o[0]), 64'(C_NONE));
    chk("t2_s4", 0, 64'(st_o[0]), 64'd0);
    chk("t2_c4_lat4", 1, 64'(ctrl_o[1]), 64'(C_LOAD));
    step();
    #3;
    chk("t2_c5_lat4", 1, 64'(ctrl_o[1]), 64'(C_NONE));
    step();

    // 3: branch beats load-use
    drive_load_use();
    take_branch_EX = 1'b1;
    #3;
    chk("t3_ctrl", 0, 64'(ctrl_o[0]), 64'(C_BRANCH));
    step();
    idle_in();
    #3;
    chk("t3_state", 0, 64'(st_o[0]), 64'd0);
`ifdef HAZARD_PERF_CNT_EN
    // 6: counters after scenarios 2 and 3, then clear
    chk("t6_stall", 0, 64'(pst_o[0]), 64'd3);
    chk("t6_flush", 0, 64'(pfl_o[0]), 64'd1);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    #3;
    chk("t6_clr_stall", 0, 64'(pst_o[0]), 64'd0);
    chk("t6_clr_flush", 0, 64'(pfl_o[0]), 64'd0);
`endif
    step();

    // 4: mul/div, done on 5th cycle; a branch in MD_WAIT is ignored
    md_start_EX = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      md_done = (c == 5);
      take_branch_EX = (c == 3);
      #3;
      chk($sformatf("t4_c%0d", c), 0, 64'(ctrl_o[0]), 64'((c == 5) ? C_NONE : C_MD));
      step();
    end
    idle_in();
    #3;
    chk("t4_state", 0, 64'(st_o[0]), 64'd0);
    step();

    // md_start and md_done together: no stall
    md_start_EX = 1'b1; md_done = 1'b1;
    step();
    idle_in();
    step();

    // 5: reset during the 2nd LOAD_WAIT cycle (dut1, LOAD_LAT=4)
    drive_load_use();
    step();
    idle_in();
    step();
    #1;
    chk("t5_pre", 1, 64'(st_o[1]), 64'd1);
    wR_MEM = 5'd7; rf_we_MEM = 1'b1; rf_wd_MEM = 32'h77;
    rR_ID = {5'd7, 5'd0}; rs_used_ID = 2'b10;
    rst = 1'b1;
    #1;
    chk("t5_rst_ctrl", 1, 64'(ctrl_o[1]), 64'(C_NONE));
    chk("t5_rst_fen", 1, 64'(fen_o[1]), 64'b00);
    chk("t5_rst_state", 1, 64'(st_o[1]), 64'd0);
    step();
    rst = 1'b0;
    #3;
    chk("t5_after_ctrl", 1, 64'(ctrl_o[1]), 64'(C_NONE));
    chk("t5_after_fen", 1, 64'(fen_o[1]), 64'b10);
    step();
    idle_in();
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
